jstk2_spi_ctrl: RTL and testbench
=================================

Name: jstk2_spi_ctrl

Overview:
SPI mode-0 master that runs one 5-byte full-duplex transaction with the PmodJSTK2 joystick on each rising edge of the 10 Hz update strobe.
- Sends the command/parameter bytes on DIN.
- Returns the 5 received bytes (X/Y position, buttons) on DOUT.
- Sits between the 10 Hz update divider and the joystick decode/LED logic on the 12 MHz ICEStick clock domain.

Parameters:
- SCLK_HALF, 90: CLK cycles per SCLK half-period (12 MHz / 180 = 66.67 kHz); minimum 4.
- SS_SETUP_CYC, 180: CLK cycles from SS falling to the first SCLK rising edge window (15 us).
- BYTE_GAP_CYC, 120: CLK cycles of idle SCLK between bytes, SS held low (10 us).

Ports:
- CLK  in  1  12 MHz system clock
- RST  in  1  synchronous, active-high reset
- SNDREC  in  1  update strobe from the 10 Hz divider; a transaction starts on its rising edge
- DIN  in  40  transmit bytes; DIN[39:32] is sent first, DIN[7:0] last
- MISO  in  1  serial data from the JSTK2
- SS  out  1  slave select, active low
- SCLK  out  1  serial clock, idle low
- MOSI  out  1  serial data to the JSTK2
- DOUT  out  40  received bytes; first received byte in DOUT[39:32]
- BUSY  out  1  high from trigger until transaction complete
- DONE  out  1  one-cycle pulse when DOUT updates

Behaviour:
- Reset values: SS=1, SCLK=0, MOSI=0, DOUT=0, BUSY=0, DONE=0, state IDLE, edge-detect register=0.
  - Reset mid-transaction aborts immediately; DOUT keeps no partial data.
- Edge detect: register SNDREC every cycle; trigger = SNDREC & ~prev.
  - Triggers while BUSY=1 are dropped, not queued.
- States: IDLE, SS_SETUP, SHIFT, BYTE_GAP, FINISH.
- IDLE
  - On trigger, latch DIN into the TX shift register, clear the RX register, byte count=0.
  - Next cycle: SS=0, BUSY=1, state SS_SETUP.
- SS_SETUP: count SS_SETUP_CYC cycles, then SHIFT.
  - MOSI = DIN[39] from entry.
- SHIFT: 8 bits, MSB first. Each bit:
  - SCLK low for SCLK_HALF cycles, MOSI stable.
  - On the CLK edge that drives SCLK high, sample MISO into the RX shift register.
  - SCLK high for SCLK_HALF cycles.
  - On the CLK edge that drives SCLK low, shift the TX register so MOSI presents the next bit.
- End of each byte: SCLK=0, byte count+1.
  - Count<5: go to BYTE_GAP for BYTE_GAP_CYC cycles, then SHIFT.
  - Count=5: go to FINISH.
- FINISH (one cycle): SS=1, DOUT<=RX register, DONE=1, BUSY=0, MOSI=0, then IDLE.
- Timing with defaults:
  - SS low duration = SS_SETUP_CYC + 80*SCLK_HALF + 4*BYTE_GAP_CYC = 7860 cycles.
  - SS falls 2 cycles after the CLK edge on which SNDREC is first sampled high.
- SCLK: exactly 40 rising edges per transaction; no SCLK activity while SS=1.
- DOUT holds its value between transactions; updates only in FINISH.
- SNDREC high at reset release with prev=0 produces a trigger on the first post-reset cycle.

Optional Feature:
- JSTK2_MISO_SYNC_EN defined:
  - MISO passes through a two-flop synchronizer (reset 0) before sampling.
  - The sampled value is MISO from 2 CLK cycles before the SCLK rising edge.
  - Valid because the slave changes MISO on the falling edge and SCLK_HALF>=4.
- Not defined: MISO is sampled directly; no extra flops.

Decomposition:
- Package jstk2_pkg:
  - state typedef (5 states).
  - PKT_BYTES=5.
  - command constants CMD_GET_POS=8'hC0, CMD_SET_LED=8'h84.
  - default timing values.
- One natural sub-module: jstk2_spi_byte.
  - 8-bit shift/SCLK generator with start/done handshake.
  - The top FSM sequences SS, gaps and byte count around it.

Test Plan:
- Reset, then SNDREC 0->1 with DIN=40'hC0_00_00_00_00 and MISO tied 1:
  - SS low exactly 7860 cycles; 40 SCLK rising edges; MOSI bits 11000000 then 32 zeros.
  - DONE pulse once; DOUT=40'hFF_FF_FF_FF_FF.
- Slave model returns 8'h12,8'h34,8'h56,8'h78,8'h9A (mode 0):
  - DOUT=40'h12_34_56_78_9A on DONE; BUSY low the same cycle.
- Second SNDREC rising edge issued mid-transaction:
  - Ignored; exactly one DONE pulse; next edge after completion starts a new transaction.
- Assert RST during byte 3:
  - Next cycle SS=1, SCLK=0, MOSI=0, BUSY=0, DOUT=0.
  - No DONE; a later trigger completes normally.
- SNDREC held high for 10 transactions' time:
  - Only one transaction; gap between bytes is 120 cycles with SCLK low and SS low.
- With JSTK2_MISO_SYNC_EN defined, repeat the 8'h12.. slave test:
  - Identical DOUT; SS and SCLK timing unchanged.

Source files
------------

// File: rtl/jstk2_pkg.sv
// Shared types and constants for the PmodJSTK2 SPI master.
package jstk2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSsSetup,
        StShift,
        StByteGap,
        StFinish
    } state_e;

    localparam int unsigned PKT_BYTES = 5;
    localparam int unsigned CNT_W     = 16;

    localparam logic [7:0] CMD_GET_POS = 8'hC0;
    localparam logic [7:0] CMD_SET_LED = 8'h84;

    localparam int unsigned SCLK_HALF_DEFAULT    = 90;
    localparam int unsigned SS_SETUP_CYC_DEFAULT = 180;
    localparam int unsigned BYTE_GAP_CYC_DEFAULT = 120;

endpackage

// File: rtl/jstk2_spi_byte.sv
// One SPI mode-0 byte: SCLK generation, MSB-first shift out on MOSI, sample MISO on SCLK rise.
module jstk2_spi_byte
    import jstk2_pkg::*;
#(
    parameter int unsigned SCLK_HALF = SCLK_HALF_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic [7:0] rx_byte,
    output logic       done
);

    logic             run_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic             sclk_q;
    logic [7:0]       tx_q;
    logic [7:0]       rx_q;
    logic             half_end;

    assign half_end = run_q && (cnt_q == CNT_W'(SCLK_HALF - 1));
    // Asserted in the cycle whose closing edge drives the 8th SCLK fall.
    assign done     = half_end && sclk_q && (bit_q == 3'd7);
    assign sclk     = sclk_q;
    assign mosi     = tx_q[7];
    assign rx_byte  = rx_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            bit_q  <= '0;
            sclk_q <= 1'b0;
            tx_q   <= '0;
            rx_q   <= '0;
        end else if (start) begin
            run_q  <= 1'b1;
            cnt_q  <= '0;
            bit_q  <= '0;
            sclk_q <= 1'b0;
            tx_q   <= tx_byte;
            rx_q   <= '0;
        end else if (run_q) begin
            if (half_end) begin
                cnt_q  <= '0;
                sclk_q <= ~sclk_q;
                if (!sclk_q) begin
                    rx_q <= {rx_q[6:0], miso};
                end else begin
                    tx_q  <= {tx_q[6:0], 1'b0};
                    bit_q <= bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        run_q <= 1'b0;
                    end
                end
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/jstk2_spi_ctrl.sv
// PmodJSTK2 5-byte SPI transaction sequencer: SS framing, setup/byte gaps, packet assembly.
// Define JSTK2_MISO_SYNC_EN to pass MISO through a two-flop synchronizer before sampling.
module jstk2_spi_ctrl
    import jstk2_pkg::*;
#(
    parameter int unsigned SCLK_HALF    = SCLK_HALF_DEFAULT,
    parameter int unsigned SS_SETUP_CYC = SS_SETUP_CYC_DEFAULT,
    parameter int unsigned BYTE_GAP_CYC = BYTE_GAP_CYC_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        SNDREC,
    input  logic [39:0] DIN,
    input  logic        MISO,
    output logic        SS,
    output logic        SCLK,
    output logic        MOSI,
    output logic [39:0] DOUT,
    output logic        BUSY,
    output logic        DONE
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       byte_cnt_q;
    logic             sndrec_q, prev_q, load_q;
    logic [39:0]      tx_q, rx_q, dout_q;
    logic             trigger, start_txn;
    logic             byte_start, byte_done, byte_mosi, miso_s;
    logic [7:0]       rx_byte;

`ifdef JSTK2_MISO_SYNC_EN
    logic [1:0] miso_sync_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            miso_sync_q <= '0;
        end else begin
            miso_sync_q <= {miso_sync_q[0], MISO};
        end
    end

    assign miso_s = miso_sync_q[1];
`else
    assign miso_s = MISO;
`endif

    // SNDREC is registered once, then edge-detected against its previous sample.
    assign trigger   = sndrec_q && !prev_q;
    assign start_txn = trigger && (state_q == StIdle) && !load_q;

    jstk2_spi_byte #(
        .SCLK_HALF(SCLK_HALF)
    ) u_byte (
        .CLK    (CLK),
        .RST    (RST),
        .start  (byte_start),
        .tx_byte(tx_q[39:32]),
        .miso   (miso_s),
        .sclk   (SCLK),
        .mosi   (byte_mosi),
        .rx_byte(rx_byte),
        .done   (byte_done)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_start = 1'b0;
        SS         = 1'b1;
        MOSI       = 1'b0;
        DONE       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load_q) begin
                    state_d = StSsSetup;
                    cnt_d   = '0;
                end
            end
            StSsSetup: begin
                SS   = 1'b0;
                MOSI = tx_q[39];
                if (cnt_q == CNT_W'(SS_SETUP_CYC - 1)) begin
                    state_d    = StShift;
                    byte_start = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StShift: begin
                SS   = 1'b0;
                MOSI = byte_mosi;
                if (byte_done) begin
                    cnt_d   = '0;
                    state_d = (byte_cnt_q == 3'(PKT_BYTES - 1)) ? StFinish : StByteGap;
                end
            end
            StByteGap: begin
                SS   = 1'b0;
                MOSI = tx_q[39];
                if (cnt_q == CNT_W'(BYTE_GAP_CYC - 1)) begin
                    state_d    = StShift;
                    byte_start = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StFinish: begin
                DONE    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign BUSY = ~SS;
    assign DOUT = dout_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            byte_cnt_q <= '0;
            sndrec_q   <= 1'b0;
            prev_q     <= 1'b0;
            load_q     <= 1'b0;
            tx_q       <= '0;
            rx_q       <= '0;
            dout_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sndrec_q <= SNDREC;
            prev_q   <= sndrec_q;
            load_q   <= start_txn;
            if (start_txn) begin
                tx_q       <= DIN;
                rx_q       <= '0;
                byte_cnt_q <= '0;
            end else if (state_q == StShift && byte_done) begin
                // Next byte's MSB lands on tx_q[39] so MOSI is ready during the gap.
                tx_q       <= {tx_q[31:0], 8'h00};
                rx_q       <= {rx_q[31:0], rx_byte};
                byte_cnt_q <= byte_cnt_q + 3'd1;
                if (byte_cnt_q == 3'(PKT_BYTES - 1)) begin
                    dout_q <= {rx_q[31:0], rx_byte};
                end
            end
        end
    end

endmodule

// File: tb/tb_jstk2_spi_ctrl.sv
// Directed bench for jstk2_spi_ctrl: framing/timing, slave loopback, dropped triggers, reset abort.
module tb_jstk2_spi_ctrl;
    import jstk2_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        SNDREC;
    logic [39:0] DIN;
    logic        MISO;
    logic        SS, SCLK, MOSI, BUSY, DONE;
    logic [39:0] DOUT;

    logic        slave_en;
    logic        miso_const;
    logic [39:0] slave_pat;
    int          slave_idx;

    int vectors = 0;
    int miscompares = 0;

    // Monitor state, written only by the negedge monitor.
    int          rise_cnt = 0;
    int          done_cnt = 0;
    int          ss_run = 0;
    int          last_ss_low = 0;
    int          lo_run = 0;
    int          rise_in_win = 0;
    int          low_run [40];
    logic [39:0] mosi_cap = '0;
    logic        ss_prev = 1'b1;
    logic        sclk_prev = 1'b0;

    jstk2_spi_ctrl dut (
        .CLK   (CLK),
        .RST   (RST),
        .SNDREC(SNDREC),
        .DIN   (DIN),
        .MISO  (MISO),
        .SS    (SS),
        .SCLK  (SCLK),
        .MOSI  (MOSI),
        .DOUT  (DOUT),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    always #5 CLK = ~CLK;

    // Mode-0 slave: bit index advances on each SCLK fall, restarts when SS rises.
    always @(negedge SCLK or posedge SS) begin
        if (SS === 1'b1) slave_idx = 0;
        else slave_idx = slave_idx + 1;
    end

    assign MISO = !slave_en ? miso_const :
                  (slave_idx < 40) ? slave_pat[6'(39 - slave_idx)] : 1'b0;

    always @(negedge CLK) begin
        if (SS === 1'b0) begin
            if (ss_prev) begin
                ss_run      = 0;
                rise_in_win = 0;
                lo_run      = 0;
            end
            ss_run = ss_run + 1;
            if (SCLK && !sclk_prev) begin
                rise_cnt = rise_cnt + 1;
                if (rise_in_win < 40) low_run[rise_in_win] = lo_run;
                rise_in_win = rise_in_win + 1;
                mosi_cap    = {mosi_cap[38:0], MOSI};
                lo_run      = 0;
            end else if (!SCLK) begin
                lo_run = lo_run + 1;
            end
        end else begin
            if (!ss_prev) last_ss_low = ss_run;
            if (SCLK === 1'b1 && !sclk_prev) rise_cnt = rise_cnt + 1;
        end
        if (DONE === 1'b1) done_cnt = done_cnt + 1;
        ss_prev   = (SS !== 1'b0);
        sclk_prev = (SCLK === 1'b1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        vectors = vectors + 1;
        assert (obs === exp)
        else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 9000 && !seen; i++) begin
            step(1);
            if (DONE === 1'b1) seen = 1'b1;
        end
        chk(tag, 40'(seen), 40'd1);
    endtask

    task automatic wait_ss_low(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1);
            if (SS === 1'b0) seen = 1'b1;
        end
        chk(tag, 40'(seen), 40'd1);
    endtask

    initial begin
        int rise_base;
        int done_base;

        RST        = 1'b1;
        SNDREC     = 1'b0;
        DIN        = '0;
        miso_const = 1'b1;
        slave_en   = 1'b0;
        slave_pat  = '0;

        step(3);
        chk("rst_ss", 40'(SS), 40'd1);
        chk("rst_sclk", 40'(SCLK), 40'd0);
        chk("rst_mosi", 40'(MOSI), 40'd0);
        chk("rst_dout", DOUT, 40'd0);
        chk("rst_busy", 40'(BUSY), 40'd0);
        chk("rst_done", 40'(DONE), 40'd0);
        RST = 1'b0;
        step(2);

        // Transaction 1: GET_POS with MISO tied high.
        DIN       = {CMD_GET_POS, 32'h0};
        rise_base = rise_cnt;
        done_base = done_cnt;
        SNDREC    = 1'b1;
        step(1);
        chk("ss_latency_1", 40'(SS), 40'd1);
        step(1);
        chk("ss_latency_2", 40'(SS), 40'd1);
        step(1);
        chk("ss_fall", 40'(SS), 40'd0);
        chk("busy_start", 40'(BUSY), 40'd1);
        chk("mosi_setup", 40'(MOSI), 40'd1);
        SNDREC = 1'b0;
        wait_done("t1_done_seen");
        chk("t1_dout", DOUT, 40'hFF_FF_FF_FF_FF);
        chk("t1_busy_at_done", 40'(BUSY), 40'd0);
        step(1);
        chk("t1_done_pulse", 40'(DONE), 40'd0);
        chk("t1_ss_low_len", 40'(last_ss_low), 40'd7860);
        chk("t1_rises", 40'(rise_cnt - rise_base), 40'd40);
        chk("t1_mosi_bits", mosi_cap, 40'hC0_00_00_00_00);
        chk("t1_done_count", 40'(done_cnt - done_base), 40'd1);
        chk("t1_setup_low", 40'(low_run[0]), 40'd270);
        chk("t1_bit_low", 40'(low_run[1]), 40'd90);
        chk("t1_gap_low", 40'(low_run[8]), 40'd210);

        // Transaction 2: slave returns 12 34 56 78 9A; a second edge mid-way is dropped.
        slave_en  = 1'b1;
        slave_pat = 40'h12_34_56_78_9A;
        DIN       = {CMD_SET_LED, 32'hA5_5A_0F_F0};
        done_base = done_cnt;
        SNDREC    = 1'b1;
        wait_ss_low("t2_ss_low_seen");
        SNDREC = 1'b0;
        step(3000);
        SNDREC = 1'b1;
        step(2);
        SNDREC = 1'b0;
        wait_done("t2_done_seen");
        chk("t2_dout", DOUT, 40'h12_34_56_78_9A);
        chk("t2_busy_at_done", 40'(BUSY), 40'd0);
        step(200);
        chk("t2_mosi_bits", mosi_cap, 40'h84_A5_5A_0F_F0);
        chk("t2_single_done", 40'(done_cnt - done_base), 40'd1);
        chk("t2_not_requeued", 40'(BUSY), 40'd0);

        // Transaction 3: reset asserted during the third byte.
        slave_pat = 40'hAB_CD_EF_01_23;
        DIN       = {CMD_GET_POS, 32'h0};
        done_base = done_cnt;
        SNDREC    = 1'b1;
        wait_ss_low("t3_ss_low_seen");
        rise_base = rise_cnt;
        SNDREC    = 1'b0;
        step(3999);
        chk("t3_rises_before_rst", 40'(rise_cnt - rise_base), 40'd20);
        RST = 1'b1;
        step(1);
        chk("abort_ss", 40'(SS), 40'd1);
        chk("abort_sclk", 40'(SCLK), 40'd0);
        chk("abort_mosi", 40'(MOSI), 40'd0);
        chk("abort_busy", 40'(BUSY), 40'd0);
        chk("abort_dout", DOUT, 40'd0);
        RST = 1'b0;
        step(50);
        chk("abort_no_done", 40'(done_cnt - done_base), 40'd0);

        // Transaction 4: SNDREC held high across several transaction lengths.
        slave_pat = 40'h12_34_56_78_9A;
        DIN       = {CMD_SET_LED, 32'h01_02_03_04};
        done_base = done_cnt;
        SNDREC    = 1'b1;
        wait_done("t4_done_seen");
        chk("t4_dout", DOUT, 40'h12_34_56_78_9A);
        step(1);
        chk("t4_ss_low_len", 40'(last_ss_low), 40'd7860);
        chk("t4_mosi_bits", mosi_cap, 40'h84_01_02_03_04);
        chk("t4_gap_low_2", 40'(low_run[16]), 40'd210);
        chk("t4_gap_low_4", 40'(low_run[32]), 40'd210);
        step(16000);
        chk("t4_single_done", 40'(done_cnt - done_base), 40'd1);
        chk("t4_idle_ss", 40'(SS), 40'd1);
        SNDREC = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
